// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch-stage state type.
package cpu_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, instr} pairs; clear overrides push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [PC_W-1:0]          push_pc,
    input  logic [INSTR_W-1:0]       push_instr,
    output logic [PC_W-1:0]          head_pc,
    output logic [INSTR_W-1:0]       head_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign do_pop     = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= NOP_INSTR;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers responses for decode.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               flushing
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    fetch_state_t  state, state_nxt;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt, drop_nxt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full, fifo_empty;
    logic            req_fire, push, pop;

    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

    // Gated by rst_n so the request port is quiet while reset is held.
    assign imem_req_valid = rst_n && (state == FETCH) && !redirect_valid
                            && (credit_used < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    assign push        = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
    assign flushing    = (state == FLUSH);

    // Redirect recomputes the stale count from scratch; the response in this cycle is already gone.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        if (redirect_valid) begin
            drop_nxt = outstanding - CW'(imem_resp_valid);
        end else if (imem_resp_valid && (drop_cnt != '0)) begin
            drop_nxt = drop_cnt - 1'b1;
        end
        unique case (state)
            FETCH: if (redirect_valid && (drop_nxt != '0)) state_nxt = FLUSH;
            FLUSH: if (drop_nxt == '0) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            drop_cnt    <= '0;
            outstanding <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
        end else begin
            state       <= state_nxt;
            drop_cnt    <= drop_nxt;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 1'b1;
                if (push)     resp_pc  <= resp_pc + 1'b1;
            end
        end
    end

    fetch_fifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .clear      (redirect_valid),
        .push_pc    (resp_pc),
        .push_instr (imem_resp_data),
        .head_pc    (pc_out),
        .head_instr (instr_out),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    no_spurious_resp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (outstanding != '0));

    credit_holds: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order variable-latency memory plus a queue-level fetch model.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_out, pc_out;
    logic        flushing;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .flushing        (flushing)
    );

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       mq[$];
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] fire_log[$], pop_log[$], popi_log[$];

    int checks = 0, failures = 0;
    int cyc = 0, lat = 1, req_mode = 0, flush_cycles = 0;
    bit ir = 1'b1, redir_req = 1'b0, arm_coinc = 1'b0, coinc_seen = 1'b0;
    logic [31:0] redir_tgt = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [31:0] at(input logic [31:0] qq[$], input int i);
        return (i < qq.size()) ? qq[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory driver, model update and per-cycle comparison.
    initial begin
        bit    resp, rv, exp_fl, exp_rv, exp_iv;
        mreq_t h;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
        redirect_valid = 0; redirect_target = '0; instr_ready = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mq.delete(); q.delete(); m_pc = RST_PC;
                imem_resp_valid = 0; redirect_valid = 0; imem_req_ready = 0; instr_ready = 0;
                #1;
                chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
                chk("rst_req_addr", imem_req_addr, RST_PC);
                chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
                chk("rst_flushing", {31'b0, flushing}, 32'd0);
                chk("rst_instr_out", instr_out, 32'd0);
                chk("rst_pc_out", pc_out, 32'd0);
            end else begin
                resp = (mq.size() > 0) && (mq[0].due <= cyc);
                imem_resp_valid = resp;
                imem_resp_data  = resp ? memfn(mq[0].addr) : 32'hDEAD_BEEF;
                imem_req_ready  = (req_mode == 0) ? 1'b1 : (req_mode == 1) ? cyc[0] : 1'b0;
                instr_ready     = ir;
                rv = redir_req;
                if (arm_coinc && resp && (q.size() > 0) && ir) begin
                    rv = 1'b1; arm_coinc = 1'b0; coinc_seen = 1'b1;
                end
                redirect_valid  = rv;
                redirect_target = redir_tgt;
                #1;
                exp_fl = 1'b0;
                foreach (mq[i]) if (mq[i].stale) exp_fl = 1'b1;
                exp_rv = !exp_fl && !rv && ((q.size() + mq.size()) < DEPTH);
                exp_iv = (q.size() > 0);
                chk("req_addr", imem_req_addr, m_pc);
                chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
                chk("flushing", {31'b0, flushing}, {31'b0, exp_fl});
                chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
                if (exp_iv) begin
                    chk("instr_out", instr_out, q[0].instr);
                    chk("pc_out", pc_out, q[0].pc);
                end
                if (exp_fl) flush_cycles++;
                if (exp_iv && ir) begin
                    pop_log.push_back(q[0].pc);
                    popi_log.push_back(q[0].instr);
                    void'(q.pop_front());
                end
                if (rv) begin
                    q.delete();
                    foreach (mq[i]) mq[i].stale = 1'b1;
                    m_pc = redir_tgt;
                end
                if (resp) begin
                    h = mq.pop_front();
                    if (!h.stale && !rv) q.push_back('{h.addr, memfn(h.addr)});
                end
                if (exp_rv && imem_req_ready) begin
                    mq.push_back('{m_pc, cyc + lat, 1'b0});
                    fire_log.push_back(m_pc);
                    m_pc = m_pc + 32'd1;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        fire_log.delete(); pop_log.delete(); popi_log.delete(); flush_cycles = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_fires(input int n);
        for (int k = 0; k < 30 && fire_log.size() < n; k++) @(posedge clk);
        if (fire_log.size() < n) begin
            failures++; checks++;
            $display("FAIL wait_fires: got %0d requests expected %0d", fire_log.size(), n);
        end
    endtask

    initial begin
        bit ok;
        // Phase 1: 1-cycle memory, decode always ready.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (16) @(posedge clk);
        chk("p1_req0", at(fire_log, 0), 32'h10);
        chk("p1_req1", at(fire_log, 1), 32'h11);
        chk("p1_req2", at(fire_log, 2), 32'h12);
        chk("p1_pop0_pc", at(pop_log, 0), 32'h10);
        chk("p1_pop0_instr", at(popi_log, 0), 32'hBEFF_0010);
        chk("p1_opcode", {26'b0, at(popi_log, 0) >> OPCODE_LSB}, 32'h2F);
        for (int i = 0; i < pop_log.size(); i++) chk("p1_pop_seq", pop_log[i], 32'h10 + i);

        // Phase 2: decode stalled fills buffer and stops requests.
        ir = 1'b0;
        do_reset();
        repeat (8) @(posedge clk);
        @(negedge clk); #2;
        chk("p2_req_count", fire_log.size(), 32'd2);
        chk("p2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("p2_instr_valid", {31'b0, instr_valid}, 32'd1);
        ir = 1'b1;
        repeat (8) @(posedge clk);
        chk("p2_pop0", at(pop_log, 0), 32'h10);
        chk("p2_pop1", at(pop_log, 1), 32'h11);
        chk("p2_req2", at(fire_log, 2), 32'h12);

        // Phase 3: toggling request ready, 2-cycle memory.
        req_mode = 1; lat = 2;
        do_reset();
        repeat (40) @(posedge clk);
        ok = 1'b1;
        for (int i = 0; i < fire_log.size(); i++) if (fire_log[i] !== 32'h10 + i) ok = 1'b0;
        chk("p3_req_contig", {31'b0, ok}, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < pop_log.size(); i++) if (pop_log[i] !== 32'h10 + i) ok = 1'b0;
        chk("p3_pop_contig", {31'b0, ok}, 32'd1);
        chk("p3_progress", {31'b0, pop_log.size() >= 5}, 32'd1);

        // Phase 4: redirect with two requests in flight on a 3-cycle memory.
        req_mode = 0; lat = 3;
        do_reset();
        wait_fires(2);
        redir_tgt = 32'h40; redir_req = 1'b1;
        @(posedge clk); redir_req = 1'b0;
        repeat (20) @(posedge clk);
        chk("p4_flush_cycles", flush_cycles, 32'd2);
        chk("p4_req_after", at(fire_log, 2), 32'h40);
        chk("p4_pop0_pc", at(pop_log, 0), 32'h40);
        chk("p4_pop0_instr", at(popi_log, 0), 32'hBEAF_0040);

        // Phase 5: redirect coinciding with a response and a decode pop.
        lat = 2;
        do_reset();
        coinc_seen = 1'b0; redir_tgt = 32'h80; arm_coinc = 1'b1;
        repeat (20) @(posedge clk);
        arm_coinc = 1'b0;
        chk("p5_coinc_seen", {31'b0, coinc_seen}, 32'd1);
        chk("p5_pop0", at(pop_log, 0), 32'h10);
        chk("p5_pop1", at(pop_log, 1), 32'h80);
        chk("p5_req2", at(fire_log, 2), 32'h80);
        chk("p5_no_flush", flush_cycles, 32'd0);

        // Phase 6: PC wrap.
        lat = 1;
        do_reset();
        redir_tgt = 32'hFFFF_FFFF; redir_req = 1'b1;
        @(posedge clk); redir_req = 1'b0;
        repeat (10) @(posedge clk);
        chk("p6_req0", at(fire_log, 0), 32'hFFFF_FFFF);
        chk("p6_req1", at(fire_log, 1), 32'h0);
        chk("p6_pop0_instr", at(popi_log, 0), 32'h4110_FFFF);
        chk("p6_pop1_pc", at(pop_log, 1), 32'h0);
        chk("p6_pop1_instr", at(popi_log, 1), 32'hBEEF_0000);

        // Phase 7: reset asserted in the middle of a flush.
        lat = 3;
        do_reset();
        wait_fires(2);
        redir_tgt = 32'h200; redir_req = 1'b1;
        @(posedge clk); redir_req = 1'b0;
        @(negedge clk); #2;
        chk("p7_flushing", {31'b0, flushing}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("p7_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("p7_rst_flushing", {31'b0, flushing}, 32'd0);
        chk("p7_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("p7_rst_req_addr", imem_req_addr, RST_PC);
        fire_log.delete(); pop_log.delete(); popi_log.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("p7_restart_req", at(fire_log, 0), 32'h10);
        chk("p7_restart_pop", at(pop_log, 0), 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
